// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - SPART bus master: programs the baud divisor, then echoes every received byte
// Bus outputs decode the state register only, so rda/tbr never reach iocs in the same cycle.
module spart_driver #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TBR_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  input  logic       rda,
  input  logic       tbr,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_drop
);

  localparam int CW = $clog2(TBR_TIMEOUT + 1);

  localparam logic [15:0] DIV_4800  = 16'((CLK_HZ + 2400) / 4800);
  localparam logic [15:0] DIV_9600  = 16'((CLK_HZ + 4800) / 9600);
  localparam logic [15:0] DIV_19200 = 16'((CLK_HZ + 9600) / 19200);
  localparam logic [15:0] DIV_38400 = 16'((CLK_HZ + 19200) / 38400);

  localparam logic [2:0] S_CFG_LO  = 3'd0;
  localparam logic [2:0] S_CFG_HI  = 3'd1;
  localparam logic [2:0] S_POLL    = 3'd2;
  localparam logic [2:0] S_RD      = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;
  localparam logic [2:0] S_WR      = 3'd5;

  logic [2:0]    r_state;
  logic          r_run;
  logic [1:0]    r_br_q;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_tx_drop;

  logic [2:0]  w_next;
  logic        w_drop;
  logic [15:0] w_div_now;
  logic [15:0] w_div_held;
  logic [7:0]  w_dout;
  logic        w_wr_state;
  logic        w_access;

  function automatic logic [15:0] div_of(input logic [1:0] sel);
    case (sel)
      2'b00:   div_of = DIV_4800;
      2'b01:   div_of = DIV_9600;
      2'b10:   div_of = DIV_19200;
      default: div_of = DIV_38400;
    endcase
  endfunction

  // Low byte uses br_cfg live in CFG_LO; high byte uses the copy captured there, so the pair never tears.
  always_comb begin
    w_div_now  = div_of(br_cfg);
    w_div_held = div_of(r_br_q);
  end

  always_comb begin
    w_next = r_state;
    w_drop = 1'b0;
    case (r_state)
      S_CFG_LO: w_next = S_CFG_HI;
      S_CFG_HI: w_next = S_POLL;
      S_POLL: begin
        if (rda)                  w_next = S_RD;
        else if (br_cfg != r_br_q) w_next = S_CFG_LO;
      end
      S_RD: w_next = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tbr) begin
          w_next = S_WR;
        end else if (r_cnt == CW'(TBR_TIMEOUT - 1)) begin
          w_next = S_POLL;
          w_drop = 1'b1;
        end
      end
      S_WR:    w_next = S_POLL;
      default: w_next = S_CFG_LO;
    endcase
  end

  // r_run holds the FSM in CFG_LO for one cycle after reset so the first write is a full cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_CFG_LO;
      r_run      <= 1'b0;
      r_br_q     <= 2'b00;
      r_cnt      <= '0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_drop  <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_rx_valid <= 1'b0;
      r_tx_drop  <= 1'b0;
      if (r_run) begin
        r_state    <= w_next;
        r_rx_valid <= (r_state == S_RD);
        r_tx_drop  <= w_drop;
        if (r_state == S_CFG_LO) r_br_q <= br_cfg;
        if (r_state == S_RD) begin
          r_rx_data <= databus;
          r_cnt     <= '0;
        end else if (r_state == S_WAIT_TX && r_cnt != '1) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_wr_state = r_run && (r_state == S_CFG_LO || r_state == S_CFG_HI || r_state == S_WR);
    w_access   = w_wr_state || (r_run && r_state == S_RD);
    w_dout     = r_rx_data;
    if (r_state == S_CFG_LO)      w_dout = w_div_now[7:0];
    else if (r_state == S_CFG_HI) w_dout = w_div_held[15:8];
  end

  assign iocs     = w_access;
  assign iorw     = !w_wr_state;
  assign ioaddr   = (r_run && r_state == S_CFG_LO) ? 2'b10 :
                    (r_run && r_state == S_CFG_HI) ? 2'b11 : 2'b00;
  assign databus  = w_wr_state ? w_dout : 8'hzz;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_drop  = r_tx_drop;

endmodule

// File: tb/tb_spart_driver.sv
// tb/tb_spart_driver.sv - scoreboard bench for spart_driver echo loop
module tb_spart_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rda, tbr, rda2, tbr2;
  logic [1:0] br_cfg;
  logic [7:0] bus_byte, bus_byte2;
  logic       iocs, iorw, iocs2, iorw2;
  logic [1:0] ioaddr, ioaddr2;
  wire  [7:0] databus, databus2;
  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, tx_drop, rx_valid2, tx_drop2;

  // SPART model: drives the rx buffer whenever the master reads
  assign databus  = (iocs && iorw) ? bus_byte : 8'hzz;
  assign databus2 = (iocs2 && iorw2) ? bus_byte2 : 8'hzz;

  spart_driver u_dut (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda), .tbr(tbr),
    .iocs(iocs), .iorw(iorw), .ioaddr(ioaddr), .databus(databus),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_drop(tx_drop)
  );

  spart_driver #(.TBR_TIMEOUT(8)) u_dut_to (
    .clk(clk), .rst(rst), .br_cfg(br_cfg), .rda(rda2), .tbr(tbr2),
    .iocs(iocs2), .iorw(iorw2), .ioaddr(ioaddr2), .databus(databus2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .tx_drop(tx_drop2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int drop_cnt = 0;
  int wr2_cnt  = 0;
  logic [9:0] exp_wr[$];
  logic [7:0] exp_rx[$];
  logic [9:0] mon_wr;
  logic [7:0] mon_rx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] div_ref(input logic [1:0] sel);
    case (sel)
      2'b00:   div_ref = 16'h5161;
      2'b01:   div_ref = 16'h28B1;
      2'b10:   div_ref = 16'h1458;
      default: div_ref = 16'h0A2C;
    endcase
  endfunction

  task automatic push_cfg(input logic [1:0] sel);
    logic [15:0] d;
    d = div_ref(sel);
    exp_wr.push_back({2'b10, d[7:0]});
    exp_wr.push_back({2'b11, d[15:8]});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (iocs && !iorw) begin
        if (exp_wr.size() == 0) check_eq("wr_unexpected", exp_wr.size(), 1);
        else begin
          mon_wr = exp_wr.pop_front();
          check_eq("bus_wr", {ioaddr, databus}, mon_wr);
        end
      end
      if (rx_valid) begin
        if (exp_rx.size() == 0) check_eq("rx_unexpected", exp_rx.size(), 1);
        else begin
          mon_rx = exp_rx.pop_front();
          check_eq("rx_data", rx_data, mon_rx);
        end
      end
      if (tx_drop) drop_cnt++;
      if (!iocs) begin
        check_eq("idle_iorw", iorw, 1);
        check_eq("idle_addr", ioaddr, 0);
      end
      if (iocs2 && !iorw2 && ioaddr2 == 2'b00) wr2_cnt++;
    end
  end

  task automatic cfg_seq_check();
    @(negedge clk); check_eq("cfg_lo", {iocs, iorw, ioaddr}, 4'b1010);
    @(negedge clk); check_eq("cfg_hi", {iocs, iorw, ioaddr}, 4'b1011);
    @(negedge clk); check_eq("cfg_done", iocs, 0);
  endtask

  task automatic wait_read(output int lat);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (iocs && iorw && ioaddr == 2'b00) break;
    end
    check_eq("read_seen", {iocs, iorw, ioaddr}, 4'b1100);
  endtask

  task automatic wait_read2(output int lat);
    lat = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      lat++;
      if (iocs2 && iorw2 && ioaddr2 == 2'b00) break;
    end
    check_eq("read2_seen", {iocs2, iorw2, ioaddr2}, 4'b1100);
  endtask

  task automatic echo(input logic [7:0] b, input int delay, input bit chg, input logic [1:0] nbr);
    int lat;
    exp_rx.push_back(b);
    exp_wr.push_back({2'b00, b});
    if (chg) push_cfg(nbr);
    tbr = (delay == 0);
    bus_byte = b;
    rda = 1'b1;
    wait_read(lat);
    check_eq("rd_latency", lat, 1);
    rda = 1'b0;
    @(negedge clk);
    check_eq("rx_valid_pulse", rx_valid, 1);
    if (chg) br_cfg = nbr;
    if (delay == 0) begin
      @(negedge clk);
      check_eq("wr_next", {iocs, iorw, ioaddr}, 4'b1000);
    end else begin
      repeat (delay) @(negedge clk);
      tbr = 1'b1;
    end
    repeat (8) @(negedge clk);
    check_eq("wr_drained", exp_wr.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int cnt;
    rst = 1'b0; br_cfg = 2'b01; rda = 1'b0; tbr = 1'b0; rda2 = 1'b0; tbr2 = 1'b0;
    bus_byte = 8'h00; bus_byte2 = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_iocs", iocs, 0);
    check_eq("rst_iorw", iorw, 1);
    check_eq("rst_addr", ioaddr, 0);
    check_eq("rst_rx_data", rx_data, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_tx_drop", tx_drop, 0);

    // 1: divisor programming after reset
    push_cfg(2'b01);
    rst = 1'b1;
    cfg_seq_check();
    repeat (3) @(negedge clk);

    // 2: immediate echo; 3: delayed tbr
    echo(8'h5A, 0, 1'b0, 2'b00);
    echo(8'h33, 10, 1'b0, 2'b00);

    // 5: idle baud change, then change deferred behind an echo
    push_cfg(2'b11);
    br_cfg = 2'b11;
    cfg_seq_check();
    repeat (2) @(negedge clk);
    echo(8'hA7, 5, 1'b1, 2'b10);

    // 6: reset asserted during WR
    exp_rx.push_back(8'h77);
    exp_wr.push_back({2'b00, 8'h77});
    tbr = 1'b0; bus_byte = 8'h77; rda = 1'b1;
    wait_read(lat);
    rda = 1'b0;
    repeat (2) @(negedge clk);
    tbr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (iocs && !iorw && ioaddr == 2'b00) break;
    end
    check_eq("wr_before_rst", {iocs, iorw, ioaddr}, 4'b1000);
    #1 rst = 1'b0;
    #1;
    check_eq("rst_async_iocs", iocs, 0);
    check_eq("rst_async_iorw", iorw, 1);
    check_eq("rst_async_rx", rx_data, 0);
    @(negedge clk);
    push_cfg(br_cfg);
    rst = 1'b1;
    cfg_seq_check();
    repeat (4) @(negedge clk);

    // 4: timeout instance with tbr stuck low
    tbr2 = 1'b0; bus_byte2 = 8'hC3; rda2 = 1'b1;
    wait_read2(lat);
    rda2 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10 && !rx_valid2; i++) @(negedge clk);
    check_eq("rx_valid2", rx_valid2, 1);
    check_eq("rx_data2", rx_data2, 8'hC3);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (tx_drop2) break;
    end
    check_eq("drop_after_cycles", cnt, 8);
    @(negedge clk);
    check_eq("drop_one_cycle", tx_drop2, 0);
    check_eq("no_wr_on_drop", wr2_cnt, 0);
    rda2 = 1'b1;
    wait_read2(lat);
    check_eq("poll_after_drop", lat, 1);
    rda2 = 1'b0;
    repeat (4) @(negedge clk);

    check_eq("main_no_drop", drop_cnt, 0);
    check_eq("wr_queue_empty", exp_wr.size(), 0);
    check_eq("rx_queue_empty", exp_rx.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
